// File: rtl/gsim_band_solver.sv
// Gauss-Seidel solver for an N x N symmetric banded Toeplitz system A*x = b.
// The band is the diagonal d plus off-diagonals a1..a3; the diagonal enters only
// through its reciprocal. b is streamed in, rows are relaxed one per cycle in
// place, and the solution is streamed out once a sweep changes nothing
// significant or the sweep cap is reached.
module gsim_band_solver #(
    parameter int N        = 16,
    parameter int B_W      = 16,
    parameter int FRAC     = 24,
    parameter int ACC_W    = 48,
    parameter int OUT_W    = 32,
    parameter int OUT_FRAC = 16,
    parameter int MAX_ITER = 75,
    parameter int TOL      = 12
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_en,
    input  logic signed [B_W-1:0]   b_in,
    input  logic signed [7:0]       coef_a1,
    input  logic signed [7:0]       coef_a2,
    input  logic signed [7:0]       coef_a3,
    input  logic        [FRAC:0]    diag_recip,
    output logic                    busy,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] x_out,
    output logic        [7:0]       iter_out,
    output logic                    converged
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);
    localparam int MW = ACC_W + FRAC;
    // A row counts as still moving when |dx| reaches 2^-TOL in real units.
    localparam logic [ACC_W-1:0] THRESH = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - TOL);

    typedef enum logic [1:0] {IDLE, LOAD, SOLVE, DRAIN} state_t;

    state_t                   state_reg, state_next;
    logic [RW-1:0]            row_reg, row_next;
    logic [7:0]               iter_reg, iter_next;
    logic                     flag_reg, flag_next;
    logic [7:0]               iter_out_reg, iter_out_next;
    logic                     conv_reg, conv_next;
    logic signed [7:0]        a_reg [3];
    logic        [FRAC:0]     recip_reg;
    logic signed [ACC_W-1:0]  x_reg [N];
    logic signed [B_W-1:0]    b_reg [N];

    logic                     load_we, capture, clear_x, upd_x;
    logic signed [ACC_W-1:0]  x_cur, s_acc, x_new, dx;
    logic        [ACC_W-1:0]  adx;
    logic signed [MW-1:0]     mul;
    logic                     big;

    // One tap per off-diagonal: a_k * (x_{i-k} + x_{i+k}), out-of-range rows read as 0.
    // Everything is kept modulo 2^ACC_W, which equals forming the full product and wrapping.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tap
            localparam int K = gi + 1;
            logic signed [ACC_W-1:0] lo;
            logic signed [ACC_W-1:0] hi;
            logic signed [ACC_W-1:0] pair;
            logic signed [ACC_W-1:0] tap;
            assign lo   = (row_reg >= RW'(K)) ? x_reg[row_reg - RW'(K)] : '0;
            assign hi   = ((int'(row_reg) + K) < N) ? x_reg[row_reg + RW'(K)] : '0;
            assign pair = lo + hi;
            assign tap  = pair * ACC_W'(a_reg[gi]);
        end
    endgenerate

    // Row update datapath: residual, scale by 1/d, and change magnitude for convergence.
    always_comb begin
        x_cur = x_reg[row_reg];
        s_acc = (ACC_W'(b_reg[row_reg]) <<< FRAC) - g_tap[0].tap - g_tap[1].tap - g_tap[2].tap;
        mul   = MW'(s_acc) * MW'($signed({1'b0, recip_reg}));
        x_new = ACC_W'(mul >>> FRAC);
        dx    = x_new - x_cur;
        adx   = dx[ACC_W-1] ? -dx : dx;
        big   = (adx >= THRESH);
    end

    // State register plus sequencing counters and the held result status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            row_reg      <= '0;
            iter_reg     <= '0;
            flag_reg     <= 1'b0;
            iter_out_reg <= '0;
            conv_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            iter_reg     <= iter_next;
            flag_reg     <= flag_next;
            iter_out_reg <= iter_out_next;
            conv_reg     <= conv_next;
        end
    end

    // Next-state logic: load beats, sweep sequencing with stop decisions, drain rows.
    always_comb begin
        state_next    = state_reg;
        row_next      = row_reg;
        iter_next     = iter_reg;
        flag_next     = flag_reg;
        iter_out_next = iter_out_reg;
        conv_next     = conv_reg;
        load_we       = 1'b0;
        capture       = 1'b0;
        clear_x       = 1'b0;
        upd_x         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_en) begin
                    capture    = 1'b1;
                    load_we    = 1'b1;
                    row_next   = RW'(1);
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (in_en) begin
                    load_we = 1'b1;
                    if (row_reg == LAST_ROW) begin
                        state_next = SOLVE;
                        row_next   = '0;
                        iter_next  = '0;
                        flag_next  = 1'b0;
                        clear_x    = 1'b1;
                    end else begin
                        row_next = row_reg + RW'(1);
                    end
                end else begin
                    // Short burst: drop what was loaded and produce nothing.
                    state_next = IDLE;
                    row_next   = '0;
                end
            end
            SOLVE: begin
                upd_x     = 1'b1;
                flag_next = (row_reg == '0) ? big : (flag_reg | big);
                if (row_reg == LAST_ROW) begin
                    iter_next = iter_reg + 8'd1;
                    row_next  = '0;
                    // Convergence wins over the cap when both happen on one sweep.
                    if (!(flag_reg | big)) begin
                        state_next    = DRAIN;
                        iter_out_next = iter_reg + 8'd1;
                        conv_next     = 1'b1;
                    end else if (iter_reg == 8'(MAX_ITER - 1)) begin
                        state_next    = DRAIN;
                        iter_out_next = iter_reg + 8'd1;
                        conv_next     = 1'b0;
                    end
                end else begin
                    row_next = row_reg + RW'(1);
                end
            end
            DRAIN: begin
                if (row_reg == LAST_ROW) begin
                    state_next = IDLE;
                    row_next   = '0;
                end else begin
                    row_next = row_reg + RW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                row_next   = '0;
            end
        endcase
    end

    // Operand storage: coefficients latched on the first beat, b per beat, x cleared then relaxed in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) a_reg[i] <= '0;
            recip_reg <= '0;
            for (int i = 0; i < N; i++) begin
                x_reg[i] <= '0;
                b_reg[i] <= '0;
            end
        end else begin
            if (capture) begin
                a_reg[0]  <= coef_a1;
                a_reg[1]  <= coef_a2;
                a_reg[2]  <= coef_a3;
                recip_reg <= diag_recip;
            end
            if (load_we) b_reg[row_reg] <= b_in;
            for (int i = 0; i < N; i++) begin
                if (clear_x) x_reg[i] <= '0;
                else if (upd_x && row_reg == RW'(i)) x_reg[i] <= x_new;
            end
        end
    end

    // Outputs follow the state directly so a reset clears them at once.
    always_comb begin
        busy      = (state_reg != IDLE);
        out_valid = (state_reg == DRAIN);
        x_out     = out_valid ? x_reg[row_reg][FRAC-OUT_FRAC +: OUT_W] : '0;
        iter_out  = iter_out_reg;
        converged = conv_reg;
    end

endmodule

// File: tb/tb_gsim_band_solver.sv
// Directed bench for gsim_band_solver: zero input, diagonal-only system,
// a mixed-sign b against a real-valued Gauss-Seidel model, the sweep cap on a
// second instance, abort/ignore behaviour of in_en, and reset mid-solve.
module tb_gsim_band_solver;

    localparam int N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n, in_en, sel;
    logic               in_en1, in_en2;
    logic signed [15:0] b_in;
    logic signed [7:0]  a1, a2, a3;
    logic        [24:0] recip;

    logic               busy1, ov1, cv1, busy2, ov2, cv2;
    logic signed [31:0] x1, x2;
    logic        [7:0]  it1, it2;

    logic               mon_busy, mon_valid, mon_conv;
    logic signed [31:0] mon_x;
    logic        [7:0]  mon_iter;

    assign in_en1    = in_en & ~sel;
    assign in_en2    = in_en & sel;
    assign mon_busy  = sel ? busy2 : busy1;
    assign mon_valid = sel ? ov2 : ov1;
    assign mon_conv  = sel ? cv2 : cv1;
    assign mon_x     = sel ? x2 : x1;
    assign mon_iter  = sel ? it2 : it1;

    gsim_band_solver u_dut (
        .clk(clk), .reset_n(reset_n), .in_en(in_en1), .b_in(b_in),
        .coef_a1(a1), .coef_a2(a2), .coef_a3(a3), .diag_recip(recip),
        .busy(busy1), .out_valid(ov1), .x_out(x1), .iter_out(it1), .converged(cv1)
    );

    gsim_band_solver #(.MAX_ITER(3), .TOL(24)) u_dut_cap (
        .clk(clk), .reset_n(reset_n), .in_en(in_en2), .b_in(b_in),
        .coef_a1(a1), .coef_a2(a2), .coef_a3(a3), .diag_recip(recip),
        .busy(busy2), .out_valid(ov2), .x_out(x2), .iter_out(it2), .converged(cv2)
    );

    int     vectors = 0;
    int     miscompares = 0;
    int     bv [N];
    longint xs [N];
    int     n_out, lat;

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_run(input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            in_en = 1'b1;
            b_in  = 16'(bv[i]);
        end
    endtask

    // Gathers the output burst; cycle 1 is the first negedge after the last beat.
    task automatic collect(input bit toggle, input int budget);
        int  idx = 0;
        bit  started = 0;
        lat = -1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (mon_valid) begin
                if (!started) begin
                    started = 1;
                    lat = cyc;
                end
                if (idx < N) xs[idx] = longint'(mon_x);
                idx++;
            end else if (started) begin
                break;
            end
            if (idx == N) break;
            in_en = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            b_in  = 16'($urandom);
        end
        in_en = 1'b0;
        n_out = idx;
    endtask

    task automatic tail(input string tag);
        @(negedge clk);
        check({tag, "_busy_end"}, mon_busy, 0);
        check({tag, "_valid_end"}, mon_valid, 0);
    endtask

    task automatic report(input string tag);
        $display("case %s: beats=%0d latency=%0d iter_out=%0d converged=%0d",
                 tag, n_out, lat, mon_iter, mon_conv);
    endtask

    task automatic run_case2(input string tag, input bit toggle);
        a1 = 8'sd0; a2 = 8'sd0; a3 = 8'sd0; recip = 25'd16777216;
        for (int i = 0; i < N; i++) bv[i] = i + 1;
        load_run(N);
        collect(toggle, 200);
        report(tag);
        check({tag, "_beats"}, n_out, N);
        check({tag, "_latency"}, lat, 2 * N + 1);
        for (int i = 0; i < N; i++) check({tag, "_x"}, xs[i], longint'(i + 1) <<< 16);
        check({tag, "_iter"}, mon_iter, 2);
        check({tag, "_conv"}, mon_conv, 1);
        tail(tag);
    endtask

    // Real-valued Gauss-Seidel reference with the same stop rule.
    real xm [N];
    int  it_m;
    bit  conv_m;

    task automatic model_run(input real ca1, input real ca2, input real ca3, input real rc,
                             input int cap, input real tol);
        bit dirty;
        real s, xn, lo, hi, ck;
        for (int i = 0; i < N; i++) xm[i] = 0.0;
        it_m = 0;
        conv_m = 0;
        do begin
            dirty = 0;
            for (int i = 0; i < N; i++) begin
                s = real'(bv[i]);
                for (int k = 1; k <= 3; k++) begin
                    ck = (k == 1) ? ca1 : (k == 2) ? ca2 : ca3;
                    lo = (i - k >= 0) ? xm[i-k] : 0.0;
                    hi = (i + k < N) ? xm[i+k] : 0.0;
                    s  = s - ck * (lo + hi);
                end
                xn = s * rc;
                if (((xn - xm[i]) >= tol) || ((xm[i] - xn) >= tol)) dirty = 1;
                xm[i] = xn;
            end
            it_m++;
        end while (dirty && it_m < cap);
        conv_m = !dirty;
    endtask

    int b_tab [N] = '{1234, -5678, 7000, -321, 42, -8000, 3999, 2500,
                      -1500, 6789, -4321, 100, -7777, 555, 3210, -2048};

    initial begin
        longint e, d;
        reset_n = 1'b0; in_en = 1'b0; sel = 1'b0; b_in = '0;
        a1 = '0; a2 = '0; a3 = '0; recip = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", mon_busy, 0);
        check("rst_valid", mon_valid, 0);
        check("rst_x", mon_x, 0);
        check("rst_iter", mon_iter, 0);
        check("rst_conv", mon_conv, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Case 1: zero right-hand side converges after one sweep.
        a1 = -8'sd13; a2 = 8'sd6; a3 = -8'sd1; recip = 25'd838861;
        for (int i = 0; i < N; i++) bv[i] = 0;
        load_run(N);
        collect(0, 200);
        report("c1");
        check("c1_beats", n_out, N);
        check("c1_latency", lat, N + 1);
        for (int i = 0; i < N; i++) check("c1_x", xs[i], 0);
        check("c1_iter", mon_iter, 1);
        check("c1_conv", mon_conv, 1);
        tail("c1");

        // Case 2: diagonal-only system, x = b.
        run_case2("c2", 0);

        // Case 3: mixed-sign b against the real-valued model.
        a1 = -8'sd13; a2 = 8'sd6; a3 = -8'sd1; recip = 25'd838861;
        for (int i = 0; i < N; i++) bv[i] = b_tab[i];
        model_run(-13.0, 6.0, -1.0, 838861.0 / 16777216.0, 75, 1.0 / 4096.0);
        load_run(N);
        collect(0, 76 * N + 20);
        report("c3");
        check("c3_beats", n_out, N);
        check("c3_latency", lat, it_m * N + 1);
        for (int i = 0; i < N; i++) begin
            e = longint'($floor(xm[i] * 65536.0));
            d = xs[i] - e;
            check("c3_x_err", (d >= -2 && d <= 2) ? 0 : d, 0);
        end
        check("c3_iter", mon_iter, it_m);
        check("c3_conv", mon_conv, conv_m);
        tail("c3");

        // Case 5a: a five-beat burst is discarded and status from case 3 is kept.
        for (int i = 0; i < N; i++) bv[i] = 100 * i;
        load_run(5);
        @(negedge clk);
        in_en = 1'b0;
        check("c5_busy_load", mon_busy, 1);
        @(negedge clk);
        check("c5_busy_abort", mon_busy, 0);
        begin
            int seen = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (mon_valid) seen++;
            end
            check("c5_no_output", seen, 0);
        end
        check("c5_iter_held", mon_iter, it_m);
        $display("case c5a: abort after 5 beats, busy=%0d", mon_busy);

        // Case 5b: in_en chatter during SOLVE/DRAIN has no effect.
        run_case2("c5b", 1);

        // Case 4: sweep cap on the second instance.
        sel = 1'b1;
        a1 = -8'sd13; a2 = 8'sd6; a3 = -8'sd1; recip = 25'd838861;
        for (int i = 0; i < N; i++) bv[i] = 1000;
        load_run(N);
        collect(0, 200);
        report("c4");
        check("c4_beats", n_out, N);
        check("c4_latency", lat, 3 * N + 1);
        check("c4_iter", mon_iter, 3);
        check("c4_conv", mon_conv, 0);
        tail("c4");
        sel = 1'b0;
        @(negedge clk);

        // Case 6: reset mid-solve clears outputs immediately, then a clean rerun.
        a1 = 8'sd0; a2 = 8'sd0; a3 = 8'sd0; recip = 25'd16777216;
        for (int i = 0; i < N; i++) bv[i] = i + 1;
        load_run(N);
        @(negedge clk);
        in_en = 1'b0;
        repeat (8) @(negedge clk);
        check("c6_busy_pre", mon_busy, 1);
        reset_n = 1'b0;
        #1;
        check("c6_rst_busy", mon_busy, 0);
        check("c6_rst_valid", mon_valid, 0);
        check("c6_rst_x", mon_x, 0);
        check("c6_rst_iter", mon_iter, 0);
        check("c6_rst_conv", mon_conv, 0);
        $display("case c6: reset asserted mid-solve");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_case2("c6", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
